coprocessor0_regfile: RTL and testbench



---
 rtl/coprocessor0_regfile_pkg.sv | 75 +++++++
 rtl/coprocessor0_regfile_timer.sv | 77 +++++++
 rtl/coprocessor0_regfile.sv | 193 +++++++++++++++++++
 tb/tb_coprocessor0_regfile.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coprocessor0_regfile_pkg.sv
// -----------------------------------------------------------------------------
// coprocessor0_params
// Shared definitions for the CP0 register file:
//   - register address/select constants for the implemented registers
//   - exception code enumeration
//   - writable-field masks for Status and Cause
//   - default exception vector
//   - request record from write-back and the Status/Cause field layouts
// Optional feature macro used by the register file: CP0_TIMER_EN.
// -----------------------------------------------------------------------------
package coprocessor0_params;

    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;
    localparam logic [2:0] CP0_SEL_DEFAULT  = 3'd0;

    // Software-writable bits: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8].
    localparam logic [31:0] STATUS_WRITE_MASK  = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WRITE_MASK   = 32'h0000_0300;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    typedef struct packed {
        logic        write_enabled;
        logic [4:0]  address_register;
        logic [2:0]  address_select;
        logic [31:0] write_data;
        logic        exception_valid;
        logic [4:0]  exception_code;
        logic [31:0] exception_address;
        logic        in_delay_slot;
        logic        eret_flish;
    } WBToCP0Data;

    typedef struct packed {
        logic [8:0] rsvd_31_23;
        logic       bev;
        logic [5:0] rsvd_21_16;
        logic [7:0] im;
        logic [5:0] rsvd_7_2;
        logic       exl;
        logic       ie;
    } StatusData;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] rsvd_29_16;
        logic [7:0]  ip;
        logic        rsvd_7;
        logic [4:0]  exc_code;
        logic [1:0]  rsvd_1_0;
    } CauseData;

    // Replace only the bits selected by mask, keep the rest of old_value.
    function automatic logic [31:0] merge_masked(input logic [31:0] old_value,
                                                 input logic [31:0] new_value,
                                                 input logic [31:0] mask);
        return (old_value & ~mask) | (new_value & mask);
    endfunction

endpackage

// File: rtl/coprocessor0_regfile_timer.sv
// -----------------------------------------------------------------------------
// coprocessor0_timer
// Count/Compare timer with a clock divider and the timer interrupt flag.
// Only instantiated when CP0_TIMER_EN is defined.
// Ports:
//   clock, reset_n   clock / asynchronous active-low reset
//   count_we         committed MTC0 to Count this cycle
//   compare_we       committed MTC0 to Compare this cycle
//   write_data       MTC0 data
//   count, compare   current register values
//   timer_int        TI flag (set on Count==Compare, cleared by Compare write)
// -----------------------------------------------------------------------------
module coprocessor0_timer #(
    parameter int COUNT_DIVIDE = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] write_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    localparam logic [3:0] DIV_LAST = 4'(COUNT_DIVIDE - 1);

    logic [3:0]  div_q, div_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    always_comb begin
        div_d     = div_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;

        // A software Count write restarts the divider phase as well.
        if (count_we) begin
            count_d = write_data;
            div_d   = 4'd0;
        end else if (div_q == DIV_LAST) begin
            div_d   = 4'd0;
            count_d = count_q + 32'd1;
        end else begin
            div_d   = div_q + 4'd1;
        end

        // Writing Compare acknowledges the timer and beats a same-cycle match.
        if (compare_we) begin
            compare_d = write_data;
            ti_d      = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d      = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q     <= 4'd0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count     = count_q;
    assign compare   = compare_q;
    assign timer_int = ti_q;

endmodule

// File: rtl/coprocessor0_regfile.sv
// -----------------------------------------------------------------------------
// coprocessor0_regfile
// CP0 register file beside the write-back stage: Status, Cause, EPC, BadVAddr
// and (optionally) Count/Compare. Commits WB's exception / ERET / MTC0 requests
// with priority exception > ERET > MTC0, serves MFC0 reads combinationally,
// and raises interrupt_request for pending enabled interrupts.
// Optional feature macro: CP0_TIMER_EN (Count/Compare timer and Cause.TI).
// Ports:
//   clock, reset_n      clock / asynchronous active-low reset
//   wb_to_cp0           request record from WB
//   wb_bad_vaddr        faulting address, used for AdEL/AdES
//   hw_interrupt        level-sensitive external interrupt lines
//   read_data           MFC0 data for the addressed register
//   status, cause, epc  current register contents
//   exception_target    exception entry address
//   interrupt_request   registered pending-and-enabled interrupt
// -----------------------------------------------------------------------------
module coprocessor0_regfile
    import coprocessor0_params::*;
#(
    parameter int          HW_INT_COUNT = 6,
    parameter int          COUNT_DIVIDE = 2,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  WBToCP0Data              wb_to_cp0,
    input  logic [31:0]             wb_bad_vaddr,
    input  logic [HW_INT_COUNT-1:0] hw_interrupt,
    output logic [31:0]             read_data,
    output StatusData               status,
    output CauseData                cause,
    output logic [31:0]             epc,
    output logic [31:0]             exception_target,
    output logic                    interrupt_request
);

    if (HW_INT_COUNT < 1 || HW_INT_COUNT > 6) begin : g_bad_hw_int_count
        $error("HW_INT_COUNT must be in 1..6");
    end
    if (COUNT_DIVIDE < 1 || COUNT_DIVIDE > 16) begin : g_bad_count_divide
        $error("COUNT_DIVIDE must be in 1..16");
    end

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [5:0]  hw_ip_q, hw_ip_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] bad_vaddr_q, bad_vaddr_d;
    logic        irq_q, irq_d;

    logic [5:0]  hw_ext;
    logic [7:0]  ip_value;
    logic        commit_write;
    logic [31:0] count_value;
    logic [31:0] compare_value;
    logic        timer_int;
    StatusData   status_wr;
    CauseData    cause_wr;

    // Zero-extend the configured interrupt lines onto the six IP[7:2] slots.
    genvar gi;
    for (gi = 0; gi < 6; gi++) begin : g_hw_map
        if (gi < HW_INT_COUNT) begin : g_used
            assign hw_ext[gi] = hw_interrupt[gi];
        end else begin : g_unused
            assign hw_ext[gi] = 1'b0;
        end
    end

    // An MTC0 only commits when no exception or ERET claims the cycle.
    assign commit_write = wb_to_cp0.write_enabled & ~wb_to_cp0.exception_valid
                        & ~wb_to_cp0.eret_flish
                        & (wb_to_cp0.address_select == CP0_SEL_DEFAULT);

`ifdef CP0_TIMER_EN
    coprocessor0_timer #(
        .COUNT_DIVIDE(COUNT_DIVIDE)
    ) u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .count_we  (commit_write && wb_to_cp0.address_register == CP0_REG_COUNT),
        .compare_we(commit_write && wb_to_cp0.address_register == CP0_REG_COMPARE),
        .write_data(wb_to_cp0.write_data),
        .count     (count_value),
        .compare   (compare_value),
        .timer_int (timer_int)
    );
`else
    assign count_value   = 32'd0;
    assign compare_value = 32'd0;
    assign timer_int     = 1'b0;
`endif

    // IP[7] is shared between the top hardware line and the timer.
    assign ip_value = {hw_ip_q[5] | timer_int, hw_ip_q[4:0], ip_sw_q};

    assign status = StatusData'({9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q});
    assign cause  = CauseData'({bd_q, timer_int, 14'd0, ip_value, 1'b0, exc_code_q, 2'b00});

    always_comb begin
        im_d        = im_q;
        exl_d       = exl_q;
        ie_d        = ie_q;
        bd_d        = bd_q;
        exc_code_d  = exc_code_q;
        ip_sw_d     = ip_sw_q;
        epc_d       = epc_q;
        bad_vaddr_d = bad_vaddr_q;
        hw_ip_d     = hw_ext;
        irq_d       = ie_q & ~exl_q & (|(ip_value & im_q));
        status_wr   = merge_masked(status, wb_to_cp0.write_data, STATUS_WRITE_MASK);
        cause_wr    = merge_masked(cause, wb_to_cp0.write_data, CAUSE_WRITE_MASK);

        if (wb_to_cp0.exception_valid) begin
            exl_d      = 1'b1;
            exc_code_d = wb_to_cp0.exception_code;
            // A nested exception must not lose the original return address.
            if (!exl_q) begin
                epc_d = wb_to_cp0.in_delay_slot ? wb_to_cp0.exception_address - 32'd4
                                                : wb_to_cp0.exception_address;
                bd_d  = wb_to_cp0.in_delay_slot;
            end
            if (wb_to_cp0.exception_code == EXC_ADEL || wb_to_cp0.exception_code == EXC_ADES) begin
                bad_vaddr_d = wb_bad_vaddr;
            end
        end else if (wb_to_cp0.eret_flish) begin
            exl_d = 1'b0;
        end else if (commit_write) begin
            case (wb_to_cp0.address_register)
                CP0_REG_STATUS: begin
                    im_d  = status_wr.im;
                    exl_d = status_wr.exl;
                    ie_d  = status_wr.ie;
                end
                CP0_REG_CAUSE: ip_sw_d = cause_wr.ip[1:0];
                CP0_REG_EPC:   epc_d   = wb_to_cp0.write_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            im_q        <= 8'd0;
            exl_q       <= 1'b0;
            ie_q        <= 1'b0;
            bd_q        <= 1'b0;
            exc_code_q  <= 5'd0;
            ip_sw_q     <= 2'd0;
            hw_ip_q     <= 6'd0;
            epc_q       <= 32'd0;
            bad_vaddr_q <= 32'd0;
            irq_q       <= 1'b0;
        end else begin
            im_q        <= im_d;
            exl_q       <= exl_d;
            ie_q        <= ie_d;
            bd_q        <= bd_d;
            exc_code_q  <= exc_code_d;
            ip_sw_q     <= ip_sw_d;
            hw_ip_q     <= hw_ip_d;
            epc_q       <= epc_d;
            bad_vaddr_q <= bad_vaddr_d;
            irq_q       <= irq_d;
        end
    end

    // MFC0 path reflects register state only, never the in-flight write.
    always_comb begin
        read_data = 32'd0;
        if (wb_to_cp0.address_select == CP0_SEL_DEFAULT) begin
            case (wb_to_cp0.address_register)
                CP0_REG_BADVADDR: read_data = bad_vaddr_q;
                CP0_REG_COUNT:    read_data = count_value;
                CP0_REG_COMPARE:  read_data = compare_value;
                CP0_REG_STATUS:   read_data = status;
                CP0_REG_CAUSE:    read_data = cause;
                CP0_REG_EPC:      read_data = epc_q;
                default:          read_data = 32'd0;
            endcase
        end
    end

    assign epc               = epc_q;
    assign exception_target  = EXC_VECTOR;
    assign interrupt_request = irq_q;

endmodule

// File: tb/tb_coprocessor0_regfile.sv
module tb_coprocessor0_regfile;
    import coprocessor0_params::*;

    localparam int DIV = 2;
`ifdef CP0_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    WBToCP0Data  wb;
    logic [31:0] wb_bad_vaddr;
    logic [5:0]  hw_interrupt;
    logic [31:0] read_data;
    StatusData   status;
    CauseData    cause;
    logic [31:0] epc;
    logic [31:0] exception_target;
    logic        interrupt_request;

    coprocessor0_regfile dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .wb_to_cp0        (wb),
        .wb_bad_vaddr     (wb_bad_vaddr),
        .hw_interrupt     (hw_interrupt),
        .read_data        (read_data),
        .status           (status),
        .cause            (cause),
        .epc              (epc),
        .exception_target (exception_target),
        .interrupt_request(interrupt_request)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    // ---------------- reference model (architectural words) ----------------
    logic [31:0] m_status, m_epc, m_badv, m_count, m_compare;
    logic        m_bd, m_ti, m_irq;
    logic [4:0]  m_exc;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_hw;
    int          m_div;

    function automatic logic [31:0] m_cause();
        logic [7:0] ip;
        ip = {m_hw[5] | m_ti, m_hw[4:0], m_ipsw};
        return {m_bd, m_ti, 14'd0, ip, 1'b0, m_exc, 2'b00};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] rg, input logic [2:0] sl);
        if (sl != 3'd0) return 32'd0;
        case (rg)
            5'd8:  return m_badv;
            5'd9:  return TIMER_ON ? m_count : 32'd0;
            5'd11: return TIMER_ON ? m_compare : 32'd0;
            5'd12: return m_status;
            5'd13: return m_cause();
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic exc, input logic eret, input logic we,
                              input logic [4:0] rg, input logic [2:0] sl, input logic [31:0] wd,
                              input logic [4:0] code, input logic [31:0] ea, input logic ds,
                              input logic [31:0] bv, input logic [5:0] hw);
        logic wr, match, irq_n;
        irq_n = m_status[0] && !m_status[1] && ((m_cause() >> 8 & m_status >> 8 & 32'hFF) != 0);
        wr = we && !exc && !eret && sl == 3'd0;
        if (TIMER_ON) begin
            match = (m_count == m_compare);
            if (wr && rg == 5'd9) begin
                m_count = wd; m_div = 0;
            end else if (m_div == DIV - 1) begin
                m_div = 0; m_count = m_count + 32'd1;
            end else begin
                m_div = m_div + 1;
            end
            if (wr && rg == 5'd11) begin
                m_compare = wd; m_ti = 1'b0;
            end else if (match) begin
                m_ti = 1'b1;
            end
        end
        if (exc) begin
            if (!m_status[1]) begin
                m_epc = ds ? ea - 32'd4 : ea;
                m_bd  = ds;
            end
            m_status[1] = 1'b1;
            m_exc = code;
            if (code == 5'd4 || code == 5'd5) m_badv = bv;
        end else if (eret) begin
            m_status[1] = 1'b0;
        end else if (wr) begin
            if (rg == 5'd12) m_status = (m_status & ~32'h0000_FF03) | (wd & 32'h0000_FF03);
            if (rg == 5'd13) m_ipsw = wd[9:8];
            if (rg == 5'd14) m_epc = wd;
        end
        m_hw  = hw;
        m_irq = irq_n;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cycle(input logic exc, input logic eret, input logic we,
                         input logic [4:0] rg, input logic [2:0] sl, input logic [31:0] wd,
                         input logic [4:0] code, input logic [31:0] ea, input logic ds,
                         input logic [31:0] bv, input logic [5:0] hw);
        wb.exception_valid   = exc;
        wb.eret_flish        = eret;
        wb.write_enabled     = we;
        wb.address_register  = rg;
        wb.address_select    = sl;
        wb.write_data        = wd;
        wb.exception_code    = code;
        wb.exception_address = ea;
        wb.in_delay_slot     = ds;
        wb_bad_vaddr         = bv;
        hw_interrupt         = hw;
        model_step(exc, eret, we, rg, sl, wd, code, ea, ds, bv, hw);
        @(posedge clock);
        #1;
        wb.exception_valid = 1'b0;
        wb.eret_flish      = 1'b0;
        wb.write_enabled   = 1'b0;
    endtask

    task automatic idle(input logic [5:0] hw);
        cycle(0, 0, 0, 5'd0, 3'd0, 32'd0, 5'd0, 32'd0, 0, 32'd0, hw);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] rg, input logic [2:0] sl,
                          input logic [31:0] exp);
        wb.address_register = rg;
        wb.address_select   = sl;
        #1;
        chk(name, read_data, exp);
    endtask

    typedef struct {
        string       name;
        logic        exc, eret, we;
        logic [4:0]  rg;
        logic [2:0]  sl;
        logic [31:0] wd;
        logic [4:0]  code;
        logic [31:0] ea;
        logic        ds;
        logic [31:0] bv;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[19];

    initial begin
        int waited;
        logic [4:0] rd_list[8];
        logic [4:0] code_list[7];

        rd_list   = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd0};
        code_list = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};

        //          name            exc eret we  rg     sl    wd              code   ea              ds  bv              rd     exp
        vecs[0]  = '{"cmp_wr",       0, 0,  1, 5'd11, 3'd0, 32'h8000_0000, 5'd0,  32'h0,          0, 32'h0,          5'd12, 32'h0040_0000};
        vecs[1]  = '{"exc_epc_ds",   1, 0,  0, 5'd0,  3'd0, 32'h0,          5'd12, 32'hBFC0_0100, 1, 32'h0,          5'd14, 32'hBFC0_00FC};
        vecs[2]  = '{"exc_cause",    0, 0,  0, 5'd0,  3'd0, 32'h0,          5'd0,  32'h0,          0, 32'h0,          5'd13, 32'h8000_0030};
        vecs[3]  = '{"exc_status",   0, 0,  0, 5'd0,  3'd0, 32'h0,          5'd0,  32'h0,          0, 32'h0,          5'd12, 32'h0040_0002};
        vecs[4]  = '{"nested_epc",   1, 0,  0, 5'd0,  3'd0, 32'h0,          5'd8,  32'h8000_0000, 0, 32'hDEAD_BEEF, 5'd14, 32'hBFC0_00FC};
        vecs[5]  = '{"nested_cause", 0, 0,  0, 5'd0,  3'd0, 32'h0,          5'd0,  32'h0,          0, 32'h0,          5'd13, 32'h8000_0020};
        vecs[6]  = '{"badv_sys",     0, 0,  0, 5'd0,  3'd0, 32'h0,          5'd0,  32'h0,          0, 32'h0,          5'd8,  32'h0};
        vecs[7]  = '{"eret_status",  0, 1,  0, 5'd0,  3'd0, 32'h0,          5'd0,  32'h0,          0, 32'h0,          5'd12, 32'h0040_0000};
        vecs[8]  = '{"adel_badv",    1, 0,  0, 5'd0,  3'd0, 32'h0,          5'd4,  32'h0000_1000, 0, 32'h0000_0003, 5'd8,  32'h0000_0003};
        vecs[9]  = '{"badv_ro",      0, 0,  1, 5'd8,  3'd0, 32'hFFFF_FFFF, 5'd0,  32'h0,          0, 32'h0,          5'd8,  32'h0000_0003};
        vecs[10] = '{"adel_epc",     0, 0,  0, 5'd0,  3'd0, 32'h0,          5'd0,  32'h0,          0, 32'h0,          5'd14, 32'h0000_1000};
        vecs[11] = '{"eret2",        0, 1,  0, 5'd0,  3'd0, 32'h0,          5'd0,  32'h0,          0, 32'h0,          5'd12, 32'h0040_0000};
        vecs[12] = '{"prio_epc",     1, 1,  1, 5'd14, 3'd0, 32'h0000_1234, 5'd12, 32'h0000_2000, 0, 32'h0,          5'd14, 32'h0000_2000};
        vecs[13] = '{"prio_status",  0, 0,  0, 5'd0,  3'd0, 32'h0,          5'd0,  32'h0,          0, 32'h0,          5'd12, 32'h0040_0002};
        vecs[14] = '{"prio_cause",   0, 1,  0, 5'd0,  3'd0, 32'h0,          5'd0,  32'h0,          0, 32'h0,          5'd13, 32'h0000_0030};
        vecs[15] = '{"status_mask",  0, 0,  1, 5'd12, 3'd0, 32'hFFFF_FFFF, 5'd0,  32'h0,          0, 32'h0,          5'd12, 32'h0040_FF03};
        vecs[16] = '{"cause_mask",   0, 0,  1, 5'd13, 3'd0, 32'hFFFF_FFFF, 5'd0,  32'h0,          0, 32'h0,          5'd13, 32'h0000_0330};
        vecs[17] = '{"unmapped",     0, 0,  1, 5'd3,  3'd0, 32'hFFFF_FFFF, 5'd0,  32'h0,          0, 32'h0,          5'd3,  32'h0};
        vecs[18] = '{"sel1_ignored", 0, 0,  1, 5'd14, 3'd1, 32'h0000_5555, 5'd0,  32'h0,          0, 32'h0,          5'd14, 32'h0000_2000};

        wb = '0;
        wb_bad_vaddr = 32'd0;
        hw_interrupt = 6'd0;
        m_status = 32'h0040_0000; m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
        m_bd = 0; m_ti = 0; m_irq = 0; m_exc = 0; m_ipsw = 0; m_hw = 0; m_div = 0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("reset_status", status, 32'h0040_0000);
        chk("reset_cause", cause, 32'h0);
        chk("reset_epc", epc, 32'h0);
        chk("reset_irq", {31'd0, interrupt_request}, 32'h0);
        chk("exc_vector", exception_target, 32'hBFC0_0380);

        // Directed table
        for (int i = 0; i < 19; i++) begin
            cycle(vecs[i].exc, vecs[i].eret, vecs[i].we, vecs[i].rg, vecs[i].sl, vecs[i].wd,
                  vecs[i].code, vecs[i].ea, vecs[i].ds, vecs[i].bv, 6'd0);
            rd_chk(vecs[i].name, vecs[i].rd, 3'd0, vecs[i].exp);
        end

        // Read path does not observe a same-cycle write
        wb.write_enabled = 1'b1; wb.address_register = 5'd14; wb.address_select = 3'd0;
        wb.write_data = 32'h0000_ABCD;
        #1;
        chk("rd_same_cycle", read_data, 32'h0000_2000);
        cycle(0, 0, 1, 5'd14, 3'd0, 32'h0000_ABCD, 5'd0, 32'd0, 0, 32'd0, 6'd0);
        rd_chk("epc_written", 5'd14, 3'd0, 32'h0000_ABCD);

        // Interrupt sequence
        cycle(0, 0, 1, 5'd12, 3'd0, 32'h0000_0401, 5'd0, 32'd0, 0, 32'd0, 6'd0);
        cycle(0, 0, 1, 5'd13, 3'd0, 32'h0000_0000, 5'd0, 32'd0, 0, 32'd0, 6'd0);
        chk("int_status", status, 32'h0040_0401);
        idle(6'd1);
        chk("int_ip2", (cause >> 10) & 32'd1, 32'd1);
        chk("int_irq_lat", {31'd0, interrupt_request}, 32'd0);
        idle(6'd1);
        chk("int_irq_set", {31'd0, interrupt_request}, 32'd1);
        cycle(1, 0, 0, 5'd0, 3'd0, 32'd0, 5'd0, 32'h0000_3000, 0, 32'd0, 6'd1);
        idle(6'd1);
        chk("int_irq_exl", {31'd0, interrupt_request}, 32'd0);
        cycle(0, 1, 0, 5'd0, 3'd0, 32'd0, 5'd0, 32'd0, 0, 32'd0, 6'd0);
        idle(6'd0);

`ifdef CP0_TIMER_EN
        cycle(0, 0, 1, 5'd11, 3'd0, 32'd5, 5'd0, 32'd0, 0, 32'd0, 6'd0);
        cycle(0, 0, 1, 5'd9, 3'd0, 32'd0, 5'd0, 32'd0, 0, 32'd0, 6'd0);
        waited = 0;
        while (!cause.ti && waited < 20) begin
            idle(6'd0);
            waited++;
        end
        chk("timer_ti_set", {31'd0, cause.ti}, 32'd1);
        rd_chk("timer_count_at_ti", 5'd9, 3'd0, 32'd5);
        cycle(0, 0, 1, 5'd11, 3'd0, 32'd100, 5'd0, 32'd0, 0, 32'd0, 6'd0);
        chk("timer_ti_clr", {31'd0, cause.ti}, 32'd0);
        cycle(0, 0, 1, 5'd9, 3'd0, 32'hFFFF_FFFF, 5'd0, 32'd0, 0, 32'd0, 6'd0);
        idle(6'd0);
        idle(6'd0);
        rd_chk("timer_wrap", 5'd9, 3'd0, 32'd0);
`endif

        // Randomised phase against the reference model
        for (int n = 0; n < 400; n++) begin
            logic exc, eret, we, ds;
            logic [4:0] rg, code;
            logic [2:0] sl;
            logic [31:0] wd, ea, bv;
            logic [5:0] hw;
            exc  = ($urandom_range(0, 9) == 0);
            eret = ($urandom_range(0, 9) == 0);
            we   = ($urandom_range(0, 9) < 4);
            rg   = rd_list[$urandom_range(0, 7)];
            sl   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            wd   = $urandom;
            code = code_list[$urandom_range(0, 6)];
            ea   = $urandom;
            ds   = 1'($urandom_range(0, 1));
            bv   = $urandom;
            hw   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : m_hw;
            cycle(exc, eret, we, rg, sl, wd, code, ea, ds, bv, hw);
            chk("rnd_status", status, m_status);
            chk("rnd_cause", cause, m_cause());
            chk("rnd_epc", epc, m_epc);
            chk("rnd_irq", {31'd0, interrupt_request}, {31'd0, m_irq});
            rg = rd_list[$urandom_range(0, 7)];
            rd_chk("rnd_read", rg, 3'd0, m_read(rg, 3'd0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
